// File: rtl/router_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : router_port_arbiter_if
// Description : Request/grant bundle between router input ports and the
//               per-output arbiter.
// Revision    : 1.0
// ============================================================================
interface router_port_arbiter_if #(
  parameter int NPORT = 16,
  parameter int AW    = 4
);
  logic [NPORT-1:0]    req;
  logic [NPORT*AW-1:0] req_dst;
  logic [NPORT-1:0]    done;
  logic [NPORT-1:0]    gnt;
  logic [NPORT-1:0]    out_busy;
  logic [NPORT*AW-1:0] out_src;
  logic [NPORT-1:0]    timeout;

  modport master (
    output req, req_dst, done,
    input  gnt, out_busy, out_src, timeout
  );

  modport slave (
    input  req, req_dst, done,
    output gnt, out_busy, out_src, timeout
  );
endinterface
`default_nettype wire

// File: rtl/router_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_port_arbiter
// Description : Per-output round-robin arbiter with hold timeout for an
//               NPORT x NPORT packet router.
// Revision    : 1.0
// ============================================================================
module router_port_arbiter #(
  parameter int NPORT    = 16,
  parameter int AW       = 4,
  parameter int MAX_HOLD = 1024
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  router_port_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  localparam int              c_HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(MAX_HOLD - 1);

  logic [NPORT-1:0] w_gnt;
  logic [NPORT-1:0] w_busy;
  logic [NPORT-1:0] w_to;
  logic [AW-1:0]    w_src [NPORT];

  // An input is granted exactly when some busy output records it as owner.
  always_comb begin
    w_gnt = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (w_busy[j]) begin
        w_gnt[w_src[j]] = 1'b1;
      end
    end
  end

  genvar j;
  generate
    for (j = 0; j < NPORT; j++) begin : g_out
      state_t          r_state;
      state_t          w_state_nxt;
      logic [AW-1:0]   r_src;
      logic [AW-1:0]   w_src_nxt;
      logic [AW-1:0]   r_rr;
      logic [AW-1:0]   w_rr_nxt;
      logic [c_HW-1:0] r_hold;
      logic [c_HW-1:0] w_hold_nxt;
      logic            r_to;
      logic            w_to_nxt;
      logic [NPORT-1:0] w_cand;
      logic [AW-1:0]   w_pick;
      logic [AW-1:0]   w_idx;
      logic            w_found;
      logic            w_expire;
      logic            w_release;

      // Destination is only looked at when req is high, so X on an idle
      // input's req_dst cannot reach the candidate vector.
      always_comb begin
        w_cand = '0;
        for (int i = 0; i < NPORT; i++) begin
          w_cand[i] = bus.req[i] && !w_gnt[i] &&
                      (bus.req_dst[i*AW +: AW] == AW'(j));
        end
      end

      // Search upward from the round-robin pointer; AW-bit wrap gives mod NPORT.
      always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NPORT; k++) begin
          w_idx = r_rr + AW'(k);
          if (!w_found && w_cand[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
          end
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_rr_nxt    = r_rr;
        w_hold_nxt  = r_hold;
        w_to_nxt    = 1'b0;
        w_expire    = (r_hold == c_HOLD_LAST);
        w_release   = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              w_state_nxt = S_OWNED;
              w_src_nxt   = w_pick;
              w_hold_nxt  = '0;
            end
          end
          S_OWNED: begin
            w_release = bus.done[r_src] || !bus.req[r_src] || w_expire;
            if (w_release) begin
              w_state_nxt = S_IDLE;
              w_src_nxt   = '0;
              w_rr_nxt    = r_src + AW'(1);
              w_hold_nxt  = '0;
              // A packet finishing on the last allowed cycle is a clean release.
              w_to_nxt    = w_expire && !bus.done[r_src];
            end else if (r_hold != {c_HW{1'b1}}) begin
              w_hold_nxt = r_hold + c_HW'(1);
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_src_nxt   = '0;
          end
        endcase
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_state <= S_IDLE;
          r_src   <= '0;
          r_rr    <= '0;
          r_hold  <= '0;
          r_to    <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_src   <= w_src_nxt;
          r_rr    <= w_rr_nxt;
          r_hold  <= w_hold_nxt;
          r_to    <= w_to_nxt;
        end
      end

      assign w_busy[j] = (r_state == S_OWNED);
      assign w_to[j]   = r_to;
      assign w_src[j]  = r_src;
    end
  endgenerate

  always_comb begin
    bus.out_src = '0;
    for (int k = 0; k < NPORT; k++) begin
      bus.out_src[k*AW +: AW] = w_src[k];
    end
  end

  assign bus.gnt      = w_gnt;
  assign bus.out_busy = w_busy;
  assign bus.timeout  = w_to;

endmodule
`default_nettype wire

// File: doc/router_port_arbiter.md
ROUTER_PORT_ARBITER -- requirements
Module: router_port_arbiter

Interface
REQ-001 Parameter NPORT, 16, number of router input ports and output ports.
REQ-002 Parameter AW, 4, port index width; SHALL equal log2(NPORT).
REQ-003 Parameter MAX_HOLD, 1024, maximum cycles one input may own one output.
REQ-004 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_n  in  1  reset, synchronous and active-low.
REQ-006 Port req  in  NPORT  bit i high: input i requests the output in req_dst[i].
REQ-007 Port req_dst  in  NPORT*AW  destination of input i in bits [i*AW +: AW]; sampled only while req[i] high and gnt[i] low.
REQ-008 Port done  in  NPORT  one-cycle pulse: input i's packet finished (frame_n rose after last bit).
REQ-009 Port gnt  out  NPORT  bit i high: input i owns its destination output.
REQ-010 Port out_busy  out  NPORT  bit j high: output j owned; router drives busy_n[j] = ~out_busy[j].
REQ-011 Port out_src  out  NPORT*AW  owning input index of output j; 0 when output j is idle.
REQ-012 Port timeout  out  NPORT  one-cycle pulse on bit j when output j is force-released.

Function
REQ-013 Each output j SHALL run an independent FSM with states IDLE and OWNED.
REQ-014 IDLE: candidates for output j SHALL be every input i with req[i]=1, gnt[i]=0 and req_dst[i]=j.
REQ-015 IDLE with at least one candidate: SHALL select the first candidate at or after rr_ptr[j], searching upward and wrapping from NPORT-1 to 0.
REQ-016 Grant latency SHALL be one cycle: candidate present at edge N, so gnt[i], out_busy[j] and out_src[j] are high/valid after edge N.
REQ-017 IDLE with no candidate: SHALL stay IDLE and leave all outputs unchanged.
REQ-018 OWNED: gnt[src] and out_busy[j] SHALL stay high, and req_dst changes of the owner SHALL be ignored.
REQ-019 OWNED to IDLE SHALL occur on: done[src]=1, or req[src]=0 (abort), or hold counter reaching MAX_HOLD-1.
REQ-020 On that transition, the following SHALL deassert after the same edge: gnt[src] and out_busy[j]; out_src[j] SHALL return to 0.
REQ-021 On that transition, rr_ptr[j] SHALL load (src+1) mod NPORT.
REQ-022 Re-arbitration SHALL NOT happen in the release cycle, so there is a minimum one idle cycle between owners (frameo_n gap).
REQ-023 Hold counter: clear on grant, increment each OWNED cycle, saturating width ceil(log2(MAX_HOLD)).
REQ-024 Timeout release SHALL pulse timeout[j] for exactly one cycle, coincident with out_busy[j] falling.
REQ-025 If done and timeout occur together, the release SHALL count as done and timeout[j] SHALL stay 0.
REQ-026 done[i] while gnt[i]=0 SHALL be ignored.
REQ-027 An input SHALL never be granted to two outputs at once; gnt is one-hot per input by construction of REQ-014.
REQ-028 Multiple outputs SHALL be granted in the same cycle to distinct inputs, fully concurrently.
REQ-029 X on req_dst while req[i]=0 SHALL NOT affect any output.

Reset
REQ-030 With reset_n low at a rising edge, these SHALL be 0 after that edge: all FSMs IDLE; gnt, out_busy, out_src, timeout; rr_ptr[*]; hold counters.
REQ-031 Reset mid-packet SHALL drop every grant at the reset edge, with no timeout pulse.
REQ-032 The first arbitration SHALL occur at the first edge with reset_n high.

Verification
REQ-033 Single request: req[3]=1, dst=5 at edge N -> gnt[3]=1, out_busy[5]=1, out_src[5]=3 after N; done[3] at M -> all cleared after M, rr_ptr[5]=4.
REQ-034 Contention: inputs 2, 7, 9 all to dst 0, each releasing via done -> grant order 2,7,9, then 2 again; one idle cycle between each owner.
REQ-035 Wrap: rr_ptr[0]=14, requests from inputs 1 and 15 to dst 0 -> 15 granted first, then 1.
REQ-036 Timeout: MAX_HOLD=8, owner never sends done -> release after 8 OWNED cycles with timeout[j] pulsed once; done in that same cycle -> timeout[j]=0.
REQ-037 Abort and reset: owner drops req -> release next edge without timeout; reset_n low mid-packet -> all outputs 0 after the edge; parallel grants to 16 distinct outputs occur in one cycle.
